mmstage_ctrl: RTL

Memory-stage access controller for the 5-stage MIPS pipeline. It sits between the memory-side outputs of the EX/MEM pipeline register and the data-cache port. It turns the latched dRENi/dWENi/ALUOut/store fields into a single cache request per instruction, stalls the pipeline until the cache returns dhit, and holds load data if a stall elsewhere keeps the pipeline frozen. It also sequences the processor halt and flags cache requests that never complete.

---
 rtl/control_unit_types_pkg.sv | 14 +
 rtl/cpu_types_pkg.sv | 8 +
 rtl/sat_counter.sv | 40 ++++
 rtl/mmstage_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/control_unit_types_pkg.sv
// rtl/control_unit_types_pkg.sv - control unit state types and constants
package control_unit_types_pkg;

    // Default number of cycles a cache request may wait for dhit before err is raised
    localparam int MAX_WAIT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } mmstate_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath word types
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and terminal flag
module sat_counter #(
    parameter int MAX = 255,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear takes priority; clear together with enable restarts the count at 1
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = en_i ? ONE_V : '0;
        end else if (en_i && (count_q != MAX_V)) begin
            count_d = count_q + ONE_V;
        end
    end

    // Count register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == MAX_V);

endmodule

// File: rtl/mmstage_ctrl.sv
// rtl/mmstage_ctrl.sv - MEM stage data-cache access controller
module mmstage_ctrl
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dRENi,
    input  logic  dWENi,
    input  logic  halt,
    input  word_t ALUOut,
    input  word_t store,
    input  logic  pipe_en,
    input  logic  dhit,
    input  word_t dmemload,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mm_stall,
    output word_t lddata,
    output logic  halt_out,
    output logic  err
);

    mmstate_t state_q, state_d;
    word_t    lddata_q, lddata_d;
    logic     halt_q, halt_d;
    logic     err_q, err_d;
    logic     req;
    logic     cnt_clr, cnt_en, cnt_tc;
    logic     addr_lsb_unused;

    // Word-aligned addressing: the byte offset is never sent to the cache
    assign addr_lsb_unused = ^ALUOut[1:0];

    sat_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Request generation, next state, wait counting and sticky flag updates
    always_comb begin
        state_d   = state_q;
        lddata_d  = lddata_q;
        halt_d    = halt_q;
        cnt_clr   = 1'b1;
        cnt_en    = 1'b0;

        req       = (dRENi | dWENi) & ((state_q == IDLE) | (state_q == ACCESS));
        dmemWEN   = req & dWENi;
        dmemREN   = req & dRENi & ~dWENi;
        dmemaddr  = {ALUOut[31:2], 2'b00};
        dmemstore = store;
        mm_stall  = req & ~dhit;
        lddata    = ((state_q == IDLE) || (state_q == ACCESS)) ? dmemload : lddata_q;

        // A timeout is only meaningful while actually waiting on the cache
        err       = err_q | ((state_q == ACCESS) & cnt_tc);
        err_d     = err;

        if (dhit && dmemREN) begin
            lddata_d = dmemload;
        end

        case (state_q)
            IDLE: begin
                cnt_en = req & ~dhit;
                if (req) begin
                    if (!dhit) begin
                        state_d = ACCESS;
                    end else if (!pipe_en) begin
                        state_d = DONE;
                    end
                end else if (halt) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end
            end
            ACCESS: begin
                cnt_clr = 1'b0;
                cnt_en  = ~dhit;
                if (dhit) begin
                    state_d = pipe_en ? IDLE : DONE;
                end
            end
            DONE: begin
                // Hit already consumed; wait for the instruction to leave MEM
                if (pipe_en) begin
                    state_d = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign halt_out = halt_q;

    // State and sticky registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            lddata_q <= '0;
            halt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lddata_q <= lddata_d;
            halt_q   <= halt_d;
            err_q    <= err_d;
        end
    end

endmodule
